// File: rtl/prm_edge_chk_sched_if.sv
// Obstacle-code stream between the voxel streamer (master) and the scheduler (slave).
interface prm_edge_chk_sched_if #(
  parameter int CODE_W = 15
);
  logic              obs_valid;
  logic [CODE_W-1:0] obs_code;
  logic              obs_last;
  logic              obs_ready;

  modport master (output obs_valid, output obs_code, output obs_last, input obs_ready);
  modport slave  (input obs_valid, input obs_code, input obs_last, output obs_ready);
endinterface

// File: rtl/prm_edge_chk_sched.sv
// PRM edge-check scheduler: feeds one obstacle code per cycle to a combinational
// checker bank and ORs the returned edge masks over a batch.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | waiting for start; last batch result held on outputs
// S_RUN   | accepting codes; accumulating the previous cycle's mask
// S_DRAIN | no more codes; ORing in the final pending mask
// S_DONE  | one-cycle done pulse, then back to S_IDLE
module prm_edge_chk_sched #(
  parameter int CODE_W = 15,
  parameter int EDGE_N = 64,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  prm_edge_chk_sched_if.slave obs,
  output logic [CODE_W-1:0]   chk_code,
  input  logic [EDGE_N-1:0]   chk_mask,
  output logic [EDGE_N-1:0]   blocked_mask,
  output logic                all_blocked,
  output logic [CNT_W-1:0]    obs_count,
  output logic                busy,
  output logic                done,
  output logic                aborted
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [CODE_W-1:0]   chk_code_q, chk_code_d;
  logic                chk_vld_q, chk_vld_d;
  logic [EDGE_N-1:0]   blocked_q, blocked_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                aborted_q, aborted_d;
  logic                accept;

  // Ready is gated by abort so an abort never coincides with an accept.
  assign obs.obs_ready = (state_q == S_RUN) && !abort;
  assign accept        = obs.obs_valid && obs.obs_ready;

  // Next-state, code issue and mask accumulation.
  always_comb begin
    state_d    = state_q;
    chk_code_d = chk_code_q;
    chk_vld_d  = 1'b0;
    blocked_d  = blocked_q;
    count_d    = count_q;
    aborted_d  = aborted_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          blocked_d = '0;
          count_d   = '0;
          aborted_d = 1'b0;
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          // pending chk_vld is dropped: the in-flight mask is not ORed
          aborted_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          if (chk_vld_q) blocked_d = blocked_q | chk_mask;
          if (accept) begin
            chk_code_d = obs.obs_code;
            chk_vld_d  = 1'b1;
            if (count_q != {CNT_W{1'b1}}) count_d = count_q + CNT_W'(1);
            if (obs.obs_last) state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (abort) begin
          aborted_d = 1'b1;
        end else if (chk_vld_q) begin
          blocked_d = blocked_q | chk_mask;
        end
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State and registered outputs; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      chk_code_q <= '0;
      chk_vld_q  <= 1'b0;
      blocked_q  <= '0;
      count_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      chk_code_q <= chk_code_d;
      chk_vld_q  <= chk_vld_d;
      blocked_q  <= blocked_d;
      count_q    <= count_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      aborted_q  <= aborted_d;
    end
  end

  assign chk_code     = chk_code_q;
  assign blocked_mask = blocked_q;
  assign all_blocked  = &blocked_q;
  assign obs_count    = count_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign aborted      = aborted_q;

endmodule

// File: doc/prm_edge_chk_sched.md
Name: prm_edge_chk_sched

Overview:
- Sequences obstacle-voxel codes through a bank of combinational PRM edge checkers, one code per cycle.
- Each bank slice holds EDGE_N checkers sharing one 15-bit code bus. Each checker returns one edge_mask bit.
- Accumulates the OR of the bank's mask over a batch of obstacle codes, giving the set of roadmap edges invalidated by the current obstacle set.
- Sits between the obstacle voxel streamer and the path-search edge-validity table.

Parameters:
- CODE_W, 15, width of the obstacle code driven to the checker bank (bits A..O, A = LSB).
- EDGE_N, 64, number of edge checkers in the bank slice (width of the mask vector).
- CNT_W, 16, width of the accepted-code counter.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse; begins a batch. Honoured only in IDLE.
- abort  in  1  terminates the batch. Honoured in RUN and DRAIN.
- obs_valid  in  1  obstacle code valid.
- obs_code  in  CODE_W  obstacle voxel code.
- obs_last  in  1  marks the final code of the batch; qualified by obs_valid.
- obs_ready  out  1  scheduler accepts a code this cycle.
- chk_code  out  CODE_W  registered code bus to the checker bank.
- chk_mask  in  EDGE_N  combinational bank response to chk_code.
- blocked_mask  out  EDGE_N  accumulated OR of chk_mask over the batch.
- all_blocked  out  1  blocked_mask is all ones.
- obs_count  out  CNT_W  codes accepted this batch; saturating.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse at batch completion.
- aborted  out  1  batch ended via abort; held until next start.

Behaviour:
- Reset (rst_n=0 at a clock edge), from any state including mid-batch:
  - state=IDLE.
  - chk_code=0, chk_vld=0.
  - blocked_mask=0, obs_count=0.
  - obs_ready=0, busy=0, done=0, aborted=0, all_blocked=0.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - obs_ready=0.
  - start=1: blocked_mask<=0, obs_count<=0, aborted<=0, go to RUN.
  - blocked_mask and obs_count otherwise hold the last batch's result.
- RUN:
  - obs_ready=1 (combinational from state and abort; 0 if abort=1).
  - Accept = obs_valid & obs_ready.
  - On accept: chk_code<=obs_code, chk_vld<=1, obs_count<=obs_count+1 (saturates at 2^CNT_W-1).
  - No accept: chk_vld<=0 and chk_code holds its value.
  - Accept with obs_last=1: go to DRAIN.
- Accumulate stage, every cycle in RUN or DRAIN: if chk_vld=1, blocked_mask<=blocked_mask|chk_mask.
- Latency:
  - Code accepted at cycle t appears on chk_code at t+1.
  - Its mask is in blocked_mask at t+2.
  - Throughput is one code per cycle with no bubbles.
- DRAIN:
  - obs_ready=0.
  - chk_vld<=0; the final pending mask is ORed in.
  - Advance to DONE in the next cycle.
- DONE: done=1 for exactly one cycle, then IDLE.
  - Minimum batch: start at t0; single last code accepted at t1; DRAIN at t2; done at t3.
- abort in RUN or DRAIN:
  - obs_ready=0 that cycle.
  - Pending chk_vld is discarded (no OR).
  - aborted<=1, go to DONE; the done pulse still fires.
  - abort and an accept never coincide, because obs_ready is gated.
- all_blocked: combinational AND-reduce of blocked_mask. Informational only; the batch continues.
- start outside IDLE, or abort in IDLE/DONE: ignored.
- obs_last with obs_valid=0: ignored.
- chk_code holds its last value when idle. The bank is purely combinational, so no isolation is needed.
- obs_count saturation leaves accumulation unaffected.

Test Plan:
- Single code: start; one code 15'h4C2F with obs_last. Bank model returns mask 64'h0000_0000_0000_0005 → chk_code=15'h4C2F one cycle after accept; done exactly 3 cycles after start; blocked_mask=64'h5; obs_count=1; aborted=0.
- Back-to-back batch: 8 codes, obs_valid held high, last on the 8th; masks are 1<<i for i=0..7 → no bubbles; blocked_mask=64'hFF; obs_count=8; done 2 cycles after the 8th accept.
- Gapped input: 4 codes with obs_valid deasserted 2 cycles between each; one mask repeats (64'h10 twice) → blocked_mask=OR of the distinct masks; no double-count side effects; obs_count=4.
- Abort mid-batch: abort in the cycle after the 3rd accept → the 3rd code's mask is excluded; aborted=1; done pulses the next cycle; obs_ready=0 in the abort cycle.
- Reset mid-batch: rst_n low for 1 cycle during RUN with blocked_mask nonzero → all outputs return to reset values; a subsequent start runs a clean batch. A start pulse during RUN is ignored.
- Saturation and all_blocked, with CNT_W=4: 20 codes whose masks cover all 64 bits → obs_count=15; all_blocked=1 once coverage is complete; the batch runs to obs_last.
